// File: rtl/life_controller.sv
`default_nettype none
// ============================================================================
// Module      : life_controller
// Description : Top-level sequencer for the 16x16 cellular-automaton board.
//               Owns the user mode (pause / run / edit), the edit cursor,
//               commits an edited pattern into the game state and paces
//               generation requests to the next-state datapath over a
//               req/ack handshake.
//
// Ports       : clk, reset              - clock, synchronous active-high reset
//               btn_run/step/edit       - one-cycle key pulses (mode control)
//               btn_up/down/left/right  - one-cycle cursor pulses
//               gen_ack, alive_any      - datapath completion + board-nonempty
//               cursor_row, cursor_col  - edit cursor position
//               edit_en, load_req       - cell-toggle enable, commit pulse
//               gen_req                 - generation request level
//               gen_count               - generations since last load/reset
//               mode                    - state encoding for display
//
// Revision    : 1.0 - initial release
// ============================================================================
module life_controller #(
    parameter int TICK_DIV = 25_000_000,
    parameter int GEN_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             btn_edit,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             gen_ack,
    input  logic             alive_any,
    output logic [3:0]       cursor_row,
    output logic [3:0]       cursor_col,
    output logic             edit_en,
    output logic             load_req,
    output logic             gen_req,
    output logic [GEN_W-1:0] gen_count,
    output logic [2:0]       mode
);

    localparam logic [2:0] c_ST_PAUSE    = 3'd0;
    localparam logic [2:0] c_ST_RUN      = 3'd1;
    localparam logic [2:0] c_ST_GEN_WAIT = 3'd2;
    localparam logic [2:0] c_ST_EDIT     = 3'd3;
    localparam logic [2:0] c_ST_LOAD     = 3'd4;

    localparam int                  c_TICK_W    = $clog2(TICK_DIV);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);

    logic [2:0]          r_state;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic                r_from_pause;    // request was a single step, not RUN pacing
    logic                r_pause_pending;
    logic [GEN_W-1:0]    r_gen_count;
    logic [3:0]          r_row;
    logic [3:0]          r_col;

    // A btn_run landing on the ack cycle still counts as a pause request.
    logic w_pause_eff;
    logic w_stop;

    assign w_pause_eff = r_pause_pending ^ btn_run;
    assign w_stop      = r_from_pause | w_pause_eff | ~alive_any;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= c_ST_PAUSE;
            r_tick_cnt      <= '0;
            r_from_pause    <= 1'b0;
            r_pause_pending <= 1'b0;
            r_gen_count     <= '0;
            r_row           <= 4'd0;
            r_col           <= 4'd0;
        end else begin
            case (r_state)
                c_ST_PAUSE: begin
                    if (btn_run) begin
                        r_state    <= c_ST_RUN;
                        r_tick_cnt <= '0;
                    end else if (btn_step) begin
                        r_state      <= c_ST_GEN_WAIT;
                        r_from_pause <= 1'b1;
                    end else if (btn_edit) begin
                        r_state <= c_ST_EDIT;
                    end
                end

                c_ST_RUN: begin
                    // btn_run beats a coincident terminal count: no request.
                    if (btn_run) begin
                        r_state <= c_ST_PAUSE;
                    end else if (r_tick_cnt == c_TICK_LAST) begin
                        r_tick_cnt   <= '0;
                        r_state      <= c_ST_GEN_WAIT;
                        r_from_pause <= 1'b0;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end

                c_ST_GEN_WAIT: begin
                    if (gen_ack) begin
                        r_gen_count     <= r_gen_count + GEN_W'(1);
                        r_pause_pending <= 1'b0;
                        r_tick_cnt      <= '0;
                        r_state         <= w_stop ? c_ST_PAUSE : c_ST_RUN;
                    end else if (btn_run) begin
                        r_pause_pending <= ~r_pause_pending;
                    end
                end

                c_ST_EDIT: begin
                    // Opposing pulses cancel; row and column move independently.
                    if (btn_up && !btn_down) begin
                        r_row <= r_row - 4'd1;
                    end else if (btn_down && !btn_up) begin
                        r_row <= r_row + 4'd1;
                    end
                    if (btn_left && !btn_right) begin
                        r_col <= r_col - 4'd1;
                    end else if (btn_right && !btn_left) begin
                        r_col <= r_col + 4'd1;
                    end
                    if (btn_edit) begin
                        r_state <= c_ST_LOAD;
                    end
                end

                c_ST_LOAD: begin
                    r_gen_count <= '0;
                    r_state     <= c_ST_PAUSE;
                end

                default: begin
                    r_state <= c_ST_PAUSE;
                end
            endcase
        end
    end

    // Moore decode of the registered state.
    assign mode       = r_state;
    assign edit_en    = (r_state == c_ST_EDIT);
    assign load_req   = (r_state == c_ST_LOAD);
    assign gen_req    = (r_state == c_ST_GEN_WAIT);
    assign gen_count  = r_gen_count;
    assign cursor_row = r_row;
    assign cursor_col = r_col;

endmodule
`default_nettype wire

// File: tb/tb_life_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_life_controller
// Description : Self-checking bench for life_controller (TICK_DIV=4).
//               Directed sequences for RUN pacing, pause, step, auto-stop
//               and reset; a vector table for the edit-cursor session.
//
// Revision    : 1.0 - initial release
// ============================================================================
module tb_life_controller;

    localparam int TICK_DIV = 4;
    localparam int GEN_W    = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             btn_run, btn_step, btn_edit;
    logic             btn_up, btn_down, btn_left, btn_right;
    logic             gen_ack, alive_any;
    logic [3:0]       cursor_row, cursor_col;
    logic             edit_en, load_req, gen_req;
    logic [GEN_W-1:0] gen_count;
    logic [2:0]       mode;

    int n_checks = 0;
    int n_errors = 0;

    life_controller #(.TICK_DIV(TICK_DIV), .GEN_W(GEN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_run    (btn_run),
        .btn_step   (btn_step),
        .btn_edit   (btn_edit),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .gen_ack    (gen_ack),
        .alive_any  (alive_any),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .edit_en    (edit_en),
        .load_req   (load_req),
        .gen_req    (gen_req),
        .gen_count  (gen_count),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       up, down, left, right, edit;
        logic [3:0] row, col;
        logic [2:0] mode;
        logic       edit_en, load_req;
    } vec_t;

    vec_t vecs [0:5];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_run();
        btn_run = 1'b1; tick(); btn_run = 1'b0;
    endtask

    task automatic pulse_step();
        btn_step = 1'b1; tick(); btn_step = 1'b0;
    endtask

    task automatic pulse_edit();
        btn_edit = 1'b1; tick(); btn_edit = 1'b0;
    endtask

    task automatic ack(input logic alive);
        gen_ack = 1'b1; alive_any = alive; tick(); gen_ack = 1'b0; alive_any = 1'b1;
    endtask

    // Cycles until gen_req is seen high, bounded.
    task automatic wait_req(output int cyc);
        cyc = 0;
        while (!gen_req && cyc < 50) begin
            tick();
            cyc++;
        end
        if (!gen_req) check("wait_req_timeout", 0, 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_mode"},     int'(mode),       0);
        check({tag, "_row"},      int'(cursor_row), 0);
        check({tag, "_col"},      int'(cursor_col), 0);
        check({tag, "_edit_en"},  int'(edit_en),    0);
        check({tag, "_load_req"}, int'(load_req),   0);
        check({tag, "_gen_req"},  int'(gen_req),    0);
        check({tag, "_count"},    int'(gen_count),  0);
    endtask

    initial begin
        int cyc;
        int hi;
        int seen;

        reset = 1'b1;
        {btn_run, btn_step, btn_edit, btn_up, btn_down, btn_left, btn_right} = '0;
        gen_ack = 1'b0; alive_any = 1'b1;

        // Cursor session: start (0,0); expected values after each edge.
        //           up down lf rt ed   row    col    mode  en  ld
        vecs[0] = {1'b1,1'b0,1'b0,1'b0,1'b0, 4'd15, 4'd0,  3'd3, 1'b1, 1'b0};
        vecs[1] = {1'b0,1'b0,1'b1,1'b0,1'b0, 4'd15, 4'd15, 3'd3, 1'b1, 1'b0};
        vecs[2] = {1'b1,1'b1,1'b0,1'b0,1'b0, 4'd15, 4'd15, 3'd3, 1'b1, 1'b0};
        vecs[3] = {1'b0,1'b1,1'b0,1'b1,1'b0, 4'd0,  4'd0,  3'd3, 1'b1, 1'b0};
        vecs[4] = {1'b0,1'b0,1'b0,1'b0,1'b1, 4'd0,  4'd0,  3'd4, 1'b0, 1'b1};
        vecs[5] = {1'b0,1'b0,1'b0,1'b0,1'b0, 4'd0,  4'd0,  3'd0, 1'b0, 1'b0};

        tick(); tick();
        reset = 1'b0;
        check_reset_state("reset");

        // 1: RUN pacing, ack in the first request cycle -> period TICK_DIV+1.
        pulse_run();
        check("run_mode", int'(mode), 1);
        wait_req(cyc);
        check("first_req_delay", cyc, 4);
        ack(1'b1);
        check("count_1", int'(gen_count), 1);
        check("req_low_after_ack", int'(gen_req), 0);
        check("back_to_run", int'(mode), 1);
        wait_req(cyc);
        check("req_period_2", cyc + 1, 5);
        ack(1'b1);
        check("count_2", int'(gen_count), 2);
        wait_req(cyc);
        check("req_period_3", cyc + 1, 5);
        ack(1'b1);
        check("count_3", int'(gen_count), 3);

        // 2: pause requested while waiting for ack.
        wait_req(cyc);
        pulse_run();
        check("pause_pending_still_wait", int'(mode), 2);
        tick(); tick();
        check("req_held", int'(gen_req), 1);
        ack(1'b1);
        check("pause_count", int'(gen_count), 4);
        check("pause_mode", int'(mode), 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (gen_req) seen++;
        end
        check("no_req_after_pause", seen, 0);

        // 3: single step with a 10-cycle ack delay.
        pulse_step();
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (gen_req) hi++;
            if (i == 9) ack(1'b1); else tick();
        end
        check("step_req_cycles", hi, 10);
        check("step_mode", int'(mode), 0);
        check("step_count", int'(gen_count), 5);
        check("step_req_low", int'(gen_req), 0);

        // 4: auto-stop on empty board; RUN ignores btn_edit.
        pulse_run();
        pulse_edit();
        check("run_ignores_edit", int'(mode), 1);
        wait_req(cyc);
        ack(1'b0);
        check("autostop_mode", int'(mode), 0);
        check("autostop_count", int'(gen_count), 6);
        tick();
        check("autostop_stays", int'(mode), 0);

        // 6a: stray acks in PAUSE and EDIT.
        ack(1'b1);
        check("stray_pause_count", int'(gen_count), 6);
        check("stray_pause_mode", int'(mode), 0);
        pulse_edit();
        check("edit_mode", int'(mode), 3);
        check("edit_en", int'(edit_en), 1);
        ack(1'b1);
        check("stray_edit_count", int'(gen_count), 6);
        check("stray_edit_mode", int'(mode), 3);

        // 5: cursor vectors and commit.
        for (int i = 0; i < 6; i++) begin
            btn_up = vecs[i].up; btn_down = vecs[i].down;
            btn_left = vecs[i].left; btn_right = vecs[i].right;
            btn_edit = vecs[i].edit;
            tick();
            {btn_up, btn_down, btn_left, btn_right, btn_edit} = '0;
            check($sformatf("vec%0d_row", i),      int'(cursor_row), int'(vecs[i].row));
            check($sformatf("vec%0d_col", i),      int'(cursor_col), int'(vecs[i].col));
            check($sformatf("vec%0d_mode", i),     int'(mode),       int'(vecs[i].mode));
            check($sformatf("vec%0d_edit_en", i),  int'(edit_en),    int'(vecs[i].edit_en));
            check($sformatf("vec%0d_load_req", i), int'(load_req),   int'(vecs[i].load_req));
        end
        check("load_clears_count", int'(gen_count), 0);

        // Cursor retained outside EDIT; cursor buttons ignored in PAUSE.
        pulse_edit();
        btn_right = 1'b1; tick(); btn_right = 1'b0;
        pulse_edit();
        tick();
        btn_down = 1'b1; tick(); btn_down = 1'b0;
        check("cursor_held_col", int'(cursor_col), 1);
        check("cursor_held_row", int'(cursor_row), 0);

        // 6b: reset in the middle of GEN_WAIT.
        pulse_step();
        ack(1'b1);
        check("pre_reset_count", int'(gen_count), 1);
        pulse_step();
        check("pre_reset_req", int'(gen_req), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("midwait_reset");
        ack(1'b1);
        check("post_reset_ack_count", int'(gen_count), 0);
        check("post_reset_ack_mode", int'(mode), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
